fir_sym_mac: RTL and testbench

Parametrised symmetric FIR filter with runtime-loadable coefficients, time-multiplexed over one pre-add/multiply/accumulate datapath. It is the next-generation filter stage of the frequency analysis datapath. Tap count, widths, output scaling and saturation are generics. A ready/valid input handshake and a coefficient write port replace fixed hard-wired taps.

---
 rtl/fir_sym_mac.sv | 250 +++++++++++++++++++++++++
 tb/tb_fir_sym_mac.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sym_mac.sv
// fir_sym_mac
//
// Symmetric FIR filter (2*NHALF taps, h[k] = h[2*NHALF-1-k]) with a
// runtime-writable coefficient bank. One pre-adder, one multiplier and one
// accumulator are time-multiplexed over the NHALF unique coefficients, so
// each accepted sample takes NHALF+2 cycles (accept, NHALF MACs, output).
//
// Ports
//   clk         clock, all state on the rising edge
//   rst         asynchronous reset, active low
//   data_valid  sample offered by the source
//   data        signed input sample (DATA_W)
//   data_ready  high while idle; a sample is taken when valid & ready
//   flush       synchronous clear of history/fill/accumulator, any state
//   coef_we     coefficient write strobe (honoured only while idle)
//   coef_addr   coefficient index; indices >= NHALF are ignored
//   coef_wdata  signed coefficient value (COEF_W)
//   fir_valid   one-cycle pulse when fir_d holds a new output
//   fir_d       signed, rounded, clamped output (OUT_W), held between pulses
//   fir_sat     set when the clamp was applied to the current fir_d
module fir_sym_mac #(
    parameter int NHALF  = 16,
    parameter int DATA_W = 16,
    parameter int COEF_W = 15,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       data_valid,
    input  logic signed [DATA_W-1:0]   data,
    output logic                       data_ready,
    input  logic                       flush,
    input  logic                       coef_we,
    input  logic [$clog2(NHALF)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]   coef_wdata,
    output logic                       fir_valid,
    output logic signed [OUT_W-1:0]    fir_d,
    output logic                       fir_sat
);

    localparam int NTAP   = 2 * NHALF;
    localparam int K_W    = $clog2(NHALF);
    localparam int X_AW   = $clog2(NTAP);
    localparam int FILL_W = $clog2(NTAP + 1);
    localparam int PROD_W = DATA_W + 1 + COEF_W;
    localparam int ACC_W  = DATA_W + 1 + COEF_W + $clog2(NHALF);
    // Clamp comparison width: wide enough for the rounded value and the
    // output limits, plus a guard bit so the limits stay positive/negative.
    localparam int RW     = ((ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t state_reg, state_next;

    logic signed [DATA_W-1:0] x_reg [NTAP];
    logic signed [DATA_W-1:0] x_src [NTAP];
    logic signed [COEF_W-1:0] c_reg [NHALF];
    logic [NHALF-1:0]         coef_sel;
    logic [FILL_W-1:0]        fill_reg;
    logic [K_W-1:0]           k_reg;
    logic signed [ACC_W-1:0]  acc_reg;

    logic accept;
    logic coef_commit;
    logic addr_ok;
    logic fill_full;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign accept      = (state_reg == S_IDLE) && data_valid && !flush;
    assign addr_ok     = ({1'b0, coef_addr} < (K_W + 1)'(NHALF));
    assign coef_commit = (state_reg == S_IDLE) && coef_we && !flush && addr_ok;
    assign fill_full   = (fill_reg == FILL_W'(NTAP));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_ready = 1'b0;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (data_valid) state_next = S_MAC;
                end
                S_MAC: begin
                    if (k_reg == K_W'(NHALF - 1)) state_next = S_OUT;
                end
                S_OUT: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
        data_ready = (state_reg == S_IDLE);
    end

    // ------------------------------------------------------------------
    // Delay line: x[0] takes the new sample, everything else shifts by one
    // ------------------------------------------------------------------
    assign x_src[0] = data;

    genvar gi;
    generate
        for (gi = 1; gi < NTAP; gi++) begin : g_shift
            assign x_src[gi] = x_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NTAP; i++) x_reg[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < NTAP; i++) x_reg[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < NTAP; i++) x_reg[i] <= x_src[i];
        end
    end

    // ------------------------------------------------------------------
    // Coefficient bank. Cleared by reset, so it lives in registers.
    // A write that lands on the accept edge is visible to that sample's
    // MAC cycles because the MACs start one edge later.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NHALF; gi++) begin : g_csel
            assign coef_sel[gi] = coef_commit && (coef_addr == K_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NHALF; i++) c_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NHALF; i++) begin
                if (coef_sel[i]) c_reg[i] <= coef_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pre-add / multiply / accumulate
    // ------------------------------------------------------------------
    logic [X_AW-1:0]          idx_a, idx_b;
    logic signed [DATA_W-1:0] xa, xb;
    logic signed [COEF_W-1:0] c_k;
    logic signed [DATA_W:0]   pre_add;
    logic signed [PROD_W-1:0] prod;

    assign idx_a   = X_AW'(k_reg);
    assign idx_b   = X_AW'(NTAP - 1) - idx_a;
    assign xa      = x_reg[idx_a];
    assign xb      = x_reg[idx_b];
    assign c_k     = c_reg[k_reg];
    assign pre_add = {xa[DATA_W-1], xa} + {xb[DATA_W-1], xb};
    assign prod    = PROD_W'(pre_add) * PROD_W'(c_k);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg  <= '0;
            k_reg    <= '0;
            fill_reg <= '0;
        end else if (flush) begin
            acc_reg  <= '0;
            k_reg    <= '0;
            fill_reg <= '0;
        end else if (accept) begin
            acc_reg  <= '0;
            k_reg    <= '0;
            if (!fill_full) fill_reg <= fill_reg + 1'b1;
        end else if (state_reg == S_MAC) begin
            acc_reg  <= acc_reg + ACC_W'(prod);
            k_reg    <= k_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output scaling: round half toward +inf, then clamp to OUT_W
    // ------------------------------------------------------------------
    logic signed [ACC_W:0] acc_ext;
    logic signed [ACC_W:0] r_val;

    // One extra bit so adding the rounding constant cannot wrap.
    assign acc_ext = (ACC_W + 1)'(acc_reg);

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic [ACC_W:0] RND_U = (ACC_W + 1)'(1) << (SHIFT - 1);
            logic signed [ACC_W:0] r_sum;
            assign r_sum = acc_ext + $signed(RND_U);
            assign r_val = r_sum >>> SHIFT;
        end else begin : g_noround
            assign r_val = acc_ext;
        end
    endgenerate

    localparam logic signed [RW-1:0] OMAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RW-1:0] OMIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [RW-1:0]    r_w;
    logic signed [OUT_W-1:0] sat_val;
    logic                    sat_flag;

    assign r_w = RW'(r_val);

    always_comb begin
        sat_val  = OUT_W'(r_w);
        sat_flag = 1'b0;
        if (r_w > OMAX) begin
            sat_val  = OUT_W'(OMAX);
            sat_flag = 1'b1;
        end else if (r_w < OMIN) begin
            sat_val  = OUT_W'(OMIN);
            sat_flag = 1'b1;
        end
    end

    // fir_d/fir_sat are refreshed on every OUT visit; the pulse only
    // announces them once the delay line holds 2*NHALF real samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fir_valid <= 1'b0;
            fir_d     <= '0;
            fir_sat   <= 1'b0;
        end else begin
            fir_valid <= 1'b0;
            if (!flush && (state_reg == S_OUT)) begin
                fir_d     <= sat_val;
                fir_sat   <= sat_flag;
                fir_valid <= fill_full;
            end
        end
    end

endmodule

// File: tb/tb_fir_sym_mac.sv
// tb_fir_sym_mac
//
// Two fir_sym_mac instances (NHALF=4; SHIFT=0 and SHIFT=1) share every
// input. A table of hand-computed vectors covers impulse, rounding and
// saturation; a behavioural golden model feeds a scoreboard queue for the
// random, coefficient-rule, throughput, flush and reset sequences.
module tb_fir_sym_mac;

    localparam int NH = 4;
    localparam int NT = 2 * NH;

    logic               clk;
    logic               rst;
    logic               data_valid;
    logic signed [15:0] data;
    logic               flush;
    logic               coef_we;
    logic [1:0]         coef_addr;
    logic signed [14:0] coef_wdata;
    logic               ready_a, ready_b;
    logic               valid_a, valid_b;
    logic signed [15:0] fir_d_a, fir_d_b;
    logic               sat_a, sat_b;

    fir_sym_mac #(.NHALF(NH), .DATA_W(16), .COEF_W(15), .OUT_W(16), .SHIFT(0)) dut_a (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
        .data_ready(ready_a), .flush(flush), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .fir_valid(valid_a), .fir_d(fir_d_a), .fir_sat(sat_a)
    );

    fir_sym_mac #(.NHALF(NH), .DATA_W(16), .COEF_W(15), .OUT_W(16), .SHIFT(1)) dut_b (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
        .data_ready(ready_b), .flush(flush), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .fir_valid(valid_b), .fir_d(fir_d_b), .fir_sat(sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int da;
        bit sa;
        int db;
        bit sb;
    } exp_t;

    typedef enum {OP_SEND, OP_FLUSH, OP_COEF} op_t;

    typedef struct {
        op_t  op;
        int   val;
        int   addr;
        bit   ev;
        exp_t e;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   pulse_cnt = 0;
    exp_t q[$];
    exp_t mon_e;
    vec_t tbl[$];

    int mx[NT];
    int mc[NH];
    int mfill;

    int imp_a[9] = '{1, 2, 3, 4, 4, 3, 2, 1, 0};
    int imp_b[9] = '{1, 1, 2, 2, 2, 2, 1, 1, 0};

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end else begin
            $display("ok   %s: %0d (t=%0t)", nm, act, $time);
        end
    endtask

    task automatic fail_evt(input string nm, input string act, input string req);
        checks++;
        failures++;
        $display("FAIL %s: got=%s expected=%s (t=%0t)", nm, act, req, $time);
    endtask

    // ---------------- golden model ----------------
    function automatic void clampr(input longint r, output int v, output bit s);
        s = 1'b0;
        if (r > 32767) begin
            v = 32767; s = 1'b1;
        end else if (r < -32768) begin
            v = -32768; s = 1'b1;
        end else begin
            v = int'(r);
        end
    endfunction

    task automatic model_accept(input int d, output bit mv, output exp_t e);
        longint acc;
        for (int i = NT - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = d;
        if (mfill < NT) mfill++;
        mv = (mfill == NT);
        acc = 0;
        for (int k = 0; k < NH; k++)
            acc += longint'(mc[k]) * (longint'(mx[k]) + longint'(mx[NT-1-k]));
        clampr(acc, e.da, e.sa);
        clampr((acc + 1) >>> 1, e.db, e.sb);
    endtask

    task automatic model_clear_history();
        for (int i = 0; i < NT; i++) mx[i] = 0;
        mfill = 0;
    endtask

    // ---------------- drivers (all return on a falling edge) ----------------
    task automatic wait_idle();
        int n = 0;
        while (!ready_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_a) fail_evt("idle_timeout", "ready_low", "ready_high");
        @(negedge clk);
    endtask

    task automatic send(input int d, input bit use_tab, input bit tev, input exp_t te,
                        input bit keep, output int waits);
        exp_t me;
        bit   mv;
        data       = 16'(d);
        data_valid = 1'b1;
        waits      = 0;
        while (!ready_a && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!ready_a) begin
            fail_evt("accept_timeout", "ready_low", "ready_high");
        end else begin
            model_accept(d, mv, me);
            if (use_tab) begin
                if (tev) q.push_back(te);
            end else if (mv) begin
                q.push_back(me);
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (!keep) data_valid = 1'b0;
    endtask

    task automatic msend(input int d);
        exp_t dummy;
        int   w;
        dummy = '{0, 1'b0, 0, 1'b0};
        send(d, 1'b0, 1'b0, dummy, 1'b0, w);
    endtask

    task automatic wcoef(input int a, input int v, input bit commit);
        if (commit) wait_idle();
        coef_addr  = 2'(a);
        coef_wdata = 15'(v);
        coef_we    = 1'b1;
        if (commit) mc[a] = v;
        @(posedge clk);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        model_clear_history();
        if (q.size() > 0) void'(q.pop_back());
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic add(input op_t op, input int val, input int addr, input bit ev,
                       input int ea, input bit sa, input int eb, input bit sb);
        vec_t v;
        v.op   = op;
        v.val  = val;
        v.addr = addr;
        v.ev   = ev;
        v.e    = '{ea, sa, eb, sb};
        tbl.push_back(v);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst && (valid_a || valid_b)) begin
            pulse_cnt++;
            chk("valid_b_vs_a", longint'(valid_b), longint'(valid_a));
            if (q.size() == 0) begin
                fail_evt("unexpected_pulse", $sformatf("fir_d=%0d", fir_d_a), "no_pulse");
            end else begin
                mon_e = q.pop_front();
                chk("fir_d_a", longint'(fir_d_a), longint'(mon_e.da));
                chk("fir_sat_a", longint'(sat_a), longint'(mon_e.sa));
                chk("fir_d_b", longint'(fir_d_b), longint'(mon_e.db));
                chk("fir_sat_b", longint'(sat_b), longint'(mon_e.sb));
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int   base;
        int   w;
        int   d;
        int   v;
        exp_t te;

        rst        = 1'b0;
        data_valid = 1'b0;
        data       = '0;
        flush      = 1'b0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        for (int i = 0; i < NH; i++) mc[i] = 0;
        model_clear_history();

        // Impulse: c={1,2,3,4}, 7 zeros, 1, 8 zeros
        for (int i = 0; i < NH; i++) add(OP_COEF, i + 1, i, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(OP_SEND, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++)
            add(OP_SEND, (i == 0) ? 1 : 0, 0, 1, imp_a[i], 0, imp_b[i], 0);
        // Rounding: c={1,0,0,0}, x[n]=n then x[n]=-n
        add(OP_FLUSH, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NH; i++) add(OP_COEF, (i == 0) ? 1 : 0, i, 0, 0, 0, 0, 0);
        for (int n = 0; n < NT; n++) add(OP_SEND, n, 0, n == NT - 1, 7, 0, 4, 0);
        add(OP_FLUSH, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < NT; n++) add(OP_SEND, -n, 0, n == NT - 1, -7, 0, -3, 0);
        // Saturation: all c=16383, constant full-scale inputs
        add(OP_FLUSH, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NH; i++) add(OP_COEF, 16383, i, 0, 0, 0, 0, 0);
        for (int n = 0; n < NT; n++) add(OP_SEND, 32767, 0, n == NT - 1, 32767, 1, 32767, 1);
        add(OP_FLUSH, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < NT; n++) add(OP_SEND, -32768, 0, n == NT - 1, -32768, 1, -32768, 1);

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_data_ready", longint'(ready_a), 1);
        chk("reset_fir_valid", longint'(valid_a), 0);
        chk("reset_fir_d_a", longint'(fir_d_a), 0);
        chk("reset_fir_sat_a", longint'(sat_a), 0);
        chk("reset_fir_d_b", longint'(fir_d_b), 0);

        // Table-driven vectors
        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_SEND:  send(tbl[i].val, 1'b1, tbl[i].ev, tbl[i].e, 1'b0, w);
                OP_FLUSH: begin wait_idle(); do_flush(); end
                OP_COEF:  wcoef(tbl[i].addr, tbl[i].val, 1'b1);
                default:  ;
            endcase
        end
        wait_idle();
        chk("table_pulse_count", pulse_cnt, 13);

        // Async reset mid-MAC, checked before any further clock edge
        msend(-32768);
        #2 rst = 1'b0;
        #1;
        chk("areset_fir_valid", longint'(valid_a), 0);
        chk("areset_fir_d", longint'(fir_d_a), 0);
        chk("areset_fir_sat", longint'(sat_a), 0);
        chk("areset_data_ready", longint'(ready_a), 1);
        for (int i = 0; i < NH; i++) mc[i] = 0;
        model_clear_history();
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Impulse after reset: coefficients are zero, so 9 zero outputs
        base = pulse_cnt;
        for (int i = 0; i < 16; i++) msend((i == 7) ? 1 : 0);
        wait_idle();
        chk("post_reset_pulses", pulse_cnt - base, 9);

        // Random coefficients and samples against the model
        for (int i = 0; i < NH; i++) wcoef(i, int'($urandom_range(0, 32767)) - 16384, 1'b1);
        for (int i = 0; i < 12; i++) msend(int'($urandom_range(0, 65535)) - 32768);

        // Write to c[0] during MAC must be dropped
        msend(int'($urandom_range(1000, 30000)));
        v = (mc[0] > 0) ? -5000 : 5000;
        wcoef(0, v, 1'b0);
        for (int i = 0; i < 3; i++) msend(int'($urandom_range(1000, 30000)));

        // Write and accept on the same edge: sample uses the new value
        wait_idle();
        coef_addr  = 2'(1);
        coef_wdata = 15'(12345);
        coef_we    = 1'b1;
        mc[1]      = 12345;
        msend(int'($urandom_range(1000, 30000)));
        coef_we = 1'b0;
        msend(int'($urandom_range(0, 65535)) - 32768);

        // Throughput: data_valid held high, one accept every NH+2 cycles
        wait_idle();
        te = '{0, 1'b0, 0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            send(int'($urandom_range(0, 65535)) - 32768, 1'b0, 1'b0, te, 1'b1, w);
            if (i > 0) chk("ready_low_cycles", w, NH + 1);
        end
        data_valid = 1'b0;

        // Flush mid-MAC after fill: that output is dropped, history zeroed
        wait_idle();
        base = pulse_cnt;
        msend(int'($urandom_range(0, 65535)) - 32768);
        do_flush();
        repeat (12) @(negedge clk);
        for (int i = 0; i < NT; i++) begin
            d = int'($urandom_range(0, 65535)) - 32768;
            msend(d);
        end
        wait_idle();
        chk("flush_pulses", pulse_cnt - base, 1);

        chk("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
